// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH x 8 register memory.
// Programmable wait states; PSLVERR on out-of-range addresses.
module apb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic [7:0] PRDATA,
  output logic       PSLVERR
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mem_q [DEPTH];
  logic       mem_we;
  logic       err;
  logic [7:0] rdata;

  assign err = 32'(addr_q) >= 32'(DEPTH);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        unique case (1'b1)
          !PSEL: state_d = IDLE;
          PSEL && !PENABLE: begin
            addr_d  = PADDR;
            wr_d    = PWRITE;
            wdata_d = PWDATA;
            cnt_d   = 4'(WAIT_STATES);
          end
          PSEL && PENABLE && (cnt_q != 4'd0):
            cnt_d = cnt_q - 4'd1;
          PSEL && PENABLE && (cnt_q == 4'd0): begin
            mem_we  = wr_q && !err;
            state_d = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        if (mem_we && addr_q == 8'(i))
          mem_q[i] <= wdata_q;
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < DEPTH; i++)
      if (addr_q == 8'(i))
        rdata = mem_q[i];
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR = PREADY && err;
  assign PRDATA  = (PREADY && !wr_q && !err) ? rdata : 8'h00;

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) that sits directly downstream of the team's APB master bridge. It consumes PSEL, PENABLE, PADDR, PWRITE and PWDATA from the bridge. It returns PREADY, PRDATA and PSLVERR. Storage is a DEPTH x 8-bit register memory with a programmable number of wait states and an error response for out-of-range addresses.

## Interface
- DEPTH, 64: number of 8-bit words; legal addresses are 0..DEPTH-1 (1..256).
- WAIT_STATES, 2: number of access cycles with PREADY low before completion (0..15).
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select from the bridge.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  word address.
- PWDATA  in  8  write data.
- PREADY  out  1  transfer completion.
- PRDATA  out  8  read data; valid only while PREADY=1 on a read.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- **State machine:** two states, IDLE and ACCESS.
  - Internal registers: addr_q[7:0], wr_q, wdata_q[7:0], cnt[3:0].
- **IDLE:**
  - Setup phase detected (PSEL=1, PENABLE=0) at a rising edge:
    - capture PADDR, PWRITE and PWDATA into addr_q, wr_q and wdata_q;
    - load cnt = WAIT_STATES;
    - go to ACCESS.
  - Any other input combination: stay in IDLE.
- **ACCESS:** evaluated at each rising edge.
  - PSEL=0 (the master aborted): go to IDLE; no memory update.
  - PSEL=1, PENABLE=0 (new setup without a completed access): recapture the inputs, reload cnt, stay in ACCESS. The previous transfer is dropped.
  - PSEL=1, PENABLE=1, cnt!=0: decrement cnt.
  - PSEL=1, PENABLE=1, cnt==0 (completing edge):
    - if wr_q=1 and there is no error, mem[addr_q] <= wdata_q;
    - go to IDLE.
- **Output decode:** combinational from registered state only, with no input-to-output path.
  - PREADY = (state==ACCESS) && (cnt==0).
  - err = (addr_q >= DEPTH).
  - PSLVERR = PREADY && err.
  - PRDATA = mem[addr_q] when PREADY && !wr_q && !err; otherwise 8'h00.
- **Errors:**
  - A write to an out-of-range address is discarded; memory is unchanged.
  - A read from an out-of-range address returns 8'h00 with PSLVERR=1.
- **Back-to-back transfers:** a completion followed by a setup on the next cycle works with no dead cycle beyond IDLE. The bridge returns to SETUP directly after PREADY.
- **Reset:** PRESETn low asynchronously forces:
  - state=IDLE, cnt=0, addr_q=0, wr_q=0, wdata_q=0;
  - every memory word = 8'h00;
  - PREADY=0, PRDATA=8'h00, PSLVERR=0.
  - A transfer in flight is aborted and its write is never committed.
  - After deassertion, the first setup is accepted on the first rising edge.

## Timing
- Edge T0: setup phase sampled. Access cycles follow at T1..T(WAIT_STATES+1).
  - PREADY is low for the first WAIT_STATES access cycles.
  - PREADY is high in access cycle WAIT_STATES+1.
  - The transfer completes at the edge that ends that cycle.
- Total transfer length: WAIT_STATES+2 cycles. With WAIT_STATES=0 this is the standard 2-cycle zero-wait APB transfer.
- Write data becomes visible to a read whose setup is sampled at or after the completing edge.
- PREADY is high for exactly one cycle per transfer.
- PSLVERR and PRDATA are 0 whenever PREADY=0.
- If PENABLE goes low while PSEL stays high and cnt>0, this is treated as a new setup, not as wait extension.

## Test plan
- **Reset:** assert PRESETn=0 mid-cycle.
  - Outputs go to 0 immediately, without waiting for PCLK.
  - After release, a read of 0x05 returns PRDATA=0x00, PSLVERR=0.
- **Wait-state write:** WAIT_STATES=2, write 0xA5 to 0x10.
  - PREADY is low for 2 access cycles and high on the 3rd; PSLVERR=0.
  - Read of 0x10 returns 0xA5 with PREADY high on its 3rd access cycle.
- **Back-to-back:** WAIT_STATES=0, write 0x3C to 0x01, then read 0x01 on the next setup.
  - Each transfer takes 2 cycles.
  - PRDATA=0x3C in the read's completion cycle.
- **Out-of-range:** DEPTH=64, write 0x55 to 0x40.
  - PREADY=1 with PSLVERR=1.
  - Read 0x40 gives PRDATA=0x00, PSLVERR=1.
  - Read 0x00 still gives 0x00.
- **Abort:** write 0x77 to 0x08 and drop PSEL during the first wait cycle.
  - PREADY is never asserted and the FSM returns to IDLE.
  - Read 0x08 returns its prior value.
- **Reset mid-access:** write 0x99 to 0x02 and assert PRESETn during the wait cycles.
  - PREADY=0 immediately.
  - After release, read 0x02 returns 0x00.
